// File: rtl/bias_ctrl_pkg.sv
// Shared types and sizing helpers for the bias_ctrl sequencer.
// DEPTH is the credit window: datapath latency plus two output slots.
package bias_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  function automatic int depth_of(input int lat);
    return lat + 2;
  endfunction

  // Index width for a counter over n entries (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of an occupancy count that must represent 0..n inclusive.
  function automatic int occ_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo
  import bias_ctrl_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    empty,
  output logic [occ_w(DEPTH)-1:0] count
);
  localparam int PW = cnt_w(DEPTH);
  localparam int OW = occ_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == OW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      count <= count + OW'(do_push) - OW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bias_ctrl.sv
// Sequencer for the bias add/requantize datapath: loads a bank of bias
// vectors, streams features through the datapath and buffers its results.
module bias_ctrl
  import bias_ctrl_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int NUM_CH = 4,
  parameter int LAT    = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [8*SIZE-1:0]   cfg_data,
  output logic                loaded,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*SIZE-1:0]   in_data,
  input  logic                in_last,
  output logic [8*SIZE-1:0]   dp_a,
  output logic [8*SIZE-1:0]   dp_b,
  input  logic [8*SIZE-1:0]   dp_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*SIZE-1:0]   out_data,
  output logic                out_last
);
  localparam int W     = 8 * SIZE;
  localparam int DEPTH = depth_of(LAT);
  localparam int CW    = cnt_w(NUM_CH);
  localparam int OW    = occ_w(DEPTH);

  state_t         state, state_nx;
  logic [CW-1:0]  wr_addr;
  logic [CW-1:0]  ch_idx;
  logic [W-1:0]   bank [NUM_CH];
  logic [LAT-1:0] vld_pn;
  logic [LAT-1:0] last_pn;
  logic [OW-1:0]  inflight;
  logic [OW-1:0]  fifo_count;
  logic           fifo_empty;
  logic [W:0]     fifo_head;
  logic           cfg_fire;
  logic           in_fire;
  logic           run_go;
  logic           room;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + OW'(vld_pn[i]);
  end

  // Credit check covers everything already committed to the output buffer,
  // so downstream backpressure can never overflow it.
  assign room     = ({1'b0, inflight} + {1'b0, fifo_count}) < (OW + 1)'(DEPTH);
  assign run_go   = (state == IDLE) && start && loaded;
  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign dp_a     = (state == RUN) ? in_data : '0;
  assign dp_b     = bank[ch_idx];

  always_comb begin
    state_nx  = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = !(start && loaded);
        if (run_go)        state_nx = RUN;
        else if (cfg_fire) state_nx = (NUM_CH == 1) ? IDLE : LOAD;
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_fire && (wr_addr == CW'(NUM_CH - 1))) state_nx = IDLE;
      end
      RUN: begin
        in_ready = room;
        if (in_fire && in_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_addr <= '0;
      ch_idx  <= '0;
      loaded  <= 1'b0;
      vld_pn  <= '0;
      last_pn <= '0;
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
    end else begin
      state <= state_nx;
      if (cfg_fire) begin
        if (state == IDLE) begin
          bank[0] <= cfg_data;
          wr_addr <= (NUM_CH == 1) ? '0 : CW'(1);
          loaded  <= (NUM_CH == 1);
        end else if (wr_addr == CW'(NUM_CH - 1)) begin
          bank[wr_addr] <= cfg_data;
          wr_addr       <= '0;
          loaded        <= 1'b1;
        end else begin
          bank[wr_addr] <= cfg_data;
          wr_addr       <= wr_addr + 1'b1;
        end
      end
      if (run_go)
        ch_idx <= '0;
      else if (in_fire)
        ch_idx <= (ch_idx == CW'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
      // Stage boundary: valid/last follow the data through the datapath.
      vld_pn[0]  <= in_fire;
      last_pn[0] <= in_fire && in_last;
      for (int i = 1; i < LAT; i++) begin
        vld_pn[i]  <= vld_pn[i-1];
        last_pn[i] <= last_pn[i-1];
      end
    end
  end

  sync_fifo #(
    .WIDTH(W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (vld_pn[LAT-1]),
    .push_data({dp_sum, last_pn[LAT-1]}),
    .pop      (out_valid && out_ready),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head[W:1];
  assign out_last  = !fifo_empty && fifo_head[0];

endmodule

// File: tb/tb_bias_ctrl.sv
// Scoreboard bench for bias_ctrl (SIZE=2, NUM_CH=3, LAT=1) with a behavioural
// model of the bias datapath: lane = bits [8:1] of the 9-bit signed a+b.
module tb_bias_ctrl;
  localparam int SIZE = 2;
  localparam int NUM_CH = 3;
  localparam int LAT = 1;
  localparam int W = 8 * SIZE;

  logic         clock = 1'b0;
  logic         reset;
  logic         cfg_valid, cfg_ready, loaded, start, busy, done;
  logic [W-1:0] cfg_data, in_data, dp_a, dp_b, dp_sum, out_data;
  logic         in_valid, in_ready, in_last, out_valid, out_ready, out_last;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_pop_cyc = -10;
  logic [W:0] exp_q[$];

  bias_ctrl #(.SIZE(SIZE), .NUM_CH(NUM_CH), .LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .loaded(loaded), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sum(dp_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] lane_add(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    return s[8:1];
  endfunction

  always_ff @(posedge clock) begin
    for (int i = 0; i < SIZE; i++) dp_sum[8*i +: 8] <= lane_add(dp_a[8*i +: 8], dp_b[8*i +: 8]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_output: got %h, expected no output", out_data);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[W:1]));
        check("out_last", 32'(out_last), 32'(e[0]));
      end
      if (out_last) last_pop_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cfg(input logic [W-1:0] d);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && n < 50) begin tick(); n++; end
    if (!cfg_ready) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    else tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [W-1:0] d, input logic lst, input logic [W-1:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = lst;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    else begin
      exp_q.push_back({e, lst});
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 30) begin tick(); n++; end
    if (!done) check({tag, "_done_timeout"}, 32'(done), 32'd1);
    else check({tag, "_done_latency"}, 32'(cyc), 32'(last_pop_cyc + 1));
    tick();
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_std();
    send_cfg(16'h0A0A);
    send_cfg(16'h3232);
    send_cfg(16'hCECE);
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 0; cfg_data = '0; start = 0;
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
    tick(); tick();
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_loaded",    32'(loaded),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_dp_a",      32'(dp_a),      32'd0);
    check("rst_dp_b",      32'(dp_b),      32'd0);
    reset = 1'b0;
    tick();

    // Start without load is ignored.
    pulse_start();
    check("noload_busy",     32'(busy),     32'd0);
    check("noload_in_ready", 32'(in_ready), 32'd0);

    // Load and order check.
    load_std();
    check("load_loaded", 32'(loaded), 32'd1);
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] e;
      e = (i % 3 == 0) ? 16'h3737 : (i % 3 == 1) ? 16'h4B4B : 16'h1919;
      send_vec(16'h6464, (i == 5), e);
    end
    wait_done("order");

    // Negative lanes and per-lane independence.
    pulse_start();
    send_vec(16'h9C9C, 1'b0, 16'hD3D3);
    send_vec(16'h9C9C, 1'b0, 16'hE7E7);
    send_vec(16'h9C9C, 1'b0, 16'hB5B5);
    send_vec(16'h649C, 1'b1, 16'h37D3);
    wait_done("neg");

    // Backpressure: credit window of three.
    begin
      int acc = 0;
      out_ready = 1'b0;
      pulse_start();
      in_valid = 1'b1;
      in_data  = 16'h6464;
      for (int i = 0; i < 8; i++) begin
        if (in_ready) begin
          exp_q.push_back({((acc % 3 == 0) ? 16'h3737 : (acc % 3 == 1) ? 16'h4B4B : 16'h1919), 1'b0});
          acc++;
        end
        tick();
      end
      in_valid = 1'b0;
      check("bp_accepts",  32'(acc),       32'd3);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      send_vec(16'h6464, 1'b0, 16'h3737);
      send_vec(16'h6464, 1'b0, 16'h4B4B);
      send_vec(16'h6464, 1'b1, 16'h1919);
      wait_done("bp");
    end

    // Start and cfg beat together: start wins, bank untouched.
    cfg_valid = 1'b1;
    cfg_data  = 16'h7F7F;
    start     = 1'b1;
    #1;
    check("sim_cfg_ready", 32'(cfg_ready), 32'd0);
    tick();
    start = 1'b0;
    check("sim_busy",          32'(busy),      32'd1);
    check("sim_cfg_stall_run", 32'(cfg_ready), 32'd0);
    send_vec(16'h6464, 1'b0, 16'h3737);
    send_vec(16'h6464, 1'b1, 16'h4B4B);
    wait_done("sim");
    check("sim_cfg_ready_idle", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    check("sim_load_clears", 32'(loaded), 32'd0);
    send_cfg(16'h3232);
    send_cfg(16'hCECE);
    check("sim_reloaded", 32'(loaded), 32'd1);

    // Reset mid-frame with buffered results.
    out_ready = 1'b0;
    pulse_start();
    send_vec(16'h6464, 1'b0, 16'h7171);
    send_vec(16'h6464, 1'b0, 16'h4B4B);
    tick(); tick();
    check("mid_buffered", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_loaded",    32'(loaded),    32'd0);
    check("mid_out_data",  32'(out_data),  32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    check("post_rst_busy",     32'(busy),     32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bias_ctrl.md
# bias_ctrl

Sequencer and flow controller for the `bias` lane-parallel add/requantize datapath.
- Holds a bank of per-channel bias vectors and loads it from a configuration stream.
- Streams feature vectors through the datapath with valid/ready handshakes, applying the bias vectors round-robin per vector.
- Tracks in-flight data across the datapath's free-running pipeline and buffers results so downstream backpressure never drops data.
- Sits between the preceding layer's output stream and the next layer's input.

## Interface
Parameters:
- SIZE, 4 — lanes per vector; each lane is 8-bit signed.
- NUM_CH, 4 — number of bias vectors (channel groups), ≥1.
- LAT, 1 — datapath latency in cycles, ≥1.

Ports:
- clock  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-high.
- cfg_valid  in  1  — bias word offered.
- cfg_ready  out  1  — bias word accepted when high with cfg_valid.
- cfg_data  in  8*SIZE  — one bias vector.
- loaded  out  1  — bank holds NUM_CH valid words.
- start  in  1  — frame start pulse.
- busy  out  1  — high in RUN or DRAIN.
- done  out  1  — one-cycle pulse when a frame is fully drained.
- in_valid, in_ready  in/out  1  — input vector handshake.
- in_data  in  8*SIZE  — input vector.
- in_last  in  1  — marks the last vector of the frame.
- dp_a  out  8*SIZE  — drives datapath a.
- dp_b  out  8*SIZE  — drives datapath b.
- dp_sum  in  8*SIZE  — datapath result.
- out_valid, out_ready  out/in  1  — output handshake.
- out_data  out  8*SIZE  — result vector.
- out_last  out  1  — last result of the frame.

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - cfg_ready=1 unless start && loaded.
  - An accepted cfg beat writes bank[0], clears loaded, and moves to LOAD with wr_addr=1.
  - start && loaded → RUN, ch_idx=0.
  - start while !loaded is ignored.
- LOAD:
  - cfg_ready=1; each beat writes bank[wr_addr] and increments wr_addr.
  - The beat at NUM_CH-1 sets loaded=1 → IDLE.
  - NUM_CH=1 goes straight from IDLE back to IDLE with loaded=1.
  - start is ignored in LOAD.
- RUN:
  - dp_a=in_data and dp_b=bank[ch_idx], both combinational.
  - in_ready = (inflight + fifo_count < DEPTH), where DEPTH=LAT+2. There is no combinational path from out_ready.
  - On acceptance: push {1, in_last} into a LAT-deep valid/last shift register; ch_idx increments and wraps NUM_CH-1→0.
  - An accepted in_last → DRAIN.
- DRAIN:
  - in_ready=0.
  - When the shift register is empty and the FIFO is empty → IDLE, and done=1 for one cycle.
- Shift-register tail valid → push {dp_sum, last} into the output FIFO.
  - A push and a pop in the same cycle are legal when the FIFO is full.
  - The credit rule guarantees no overflow.
- out_valid = FIFO not empty; out_data/out_last come from the FIFO head.
- Arithmetic:
  - The controller never modifies data.
  - Lane i of the result is {carry, sum[7:1]} of a_i+b_i, as produced by the datapath.
- A cfg_valid outside IDLE/LOAD stalls (cfg_ready=0).
- The bank contents persist across frames; loaded persists until a new load begins.

## Timing
- Reset values:
  - cfg_ready=1 (IDLE), loaded=0, busy=0, done=0.
  - in_ready=0, out_valid=0, out_last=0.
  - out_data=0, dp_a=0, dp_b=bank[0]=0.
  - State IDLE; counters, shift register and FIFO cleared.
- Reset mid-frame: all in-flight and buffered data is discarded and the bank is invalidated.
- Latency:
  - A vector accepted at cycle t has its result written into the FIFO at the end of cycle t+LAT.
  - out_valid rises at t+LAT+1.
- Throughput: one vector per cycle when out_ready is held high.
- busy rises the cycle after start is taken and falls the cycle done pulses.
- done is asserted in the cycle the last result is popped + 1.

## Structure
- Shared package `bias_ctrl_pkg`:
  - state enum (IDLE, LOAD, RUN, DRAIN);
  - depth function DEPTH=LAT+2;
  - width helpers for counters ($clog2).
- Sub-module `sync_fifo` (parameters WIDTH=8*SIZE+1, DEPTH) for the output buffer.
- The bias bank is a register array inside bias_ctrl.
- The `bias` datapath is instantiated by the parent, not inside this block.

## Test plan
Default configuration for all scenarios: SIZE=2, NUM_CH=3, LAT=1, with the real `bias` datapath.
- Load and order check:
  - Load bias vectors {10,10}, {50,50}, {-50,-50}, then stream 6 vectors of {100,100} with out_ready=1 and last on the 6th.
  - Outputs: {55,55}, {75,75}, {25,25}, repeating once; out_last on the 6th; done one cycle later.
- Negative lanes: bias {-50,-50}, input {-100,-100} → {0xB5,0xB5} (-75).
- Backpressure:
  - Hold out_ready=0 while streaming.
  - in_ready drops after exactly 3 accepts (DEPTH); nothing is lost.
  - After release, results emerge in order.
- Start without load:
  - After reset, pulse start → busy stays 0 and in_ready stays 0.
  - Load 3 words, then start → busy=1 the next cycle.
- Simultaneous events:
  - start and cfg_valid in the same IDLE cycle with loaded=1 → RUN is entered and the cfg beat is not accepted.
  - cfg beat during RUN stalls until IDLE.
- Reset mid-frame:
  - Assert reset with 2 results buffered → out_valid=0 immediately and loaded=0.
  - Post-reset start is ignored.
